// File: rtl/conv_stream_pkg.sv
// Shared constants and state type for the conv output stream writer.
package conv_stream_pkg;

    localparam int LANES      = 16;
    localparam int LANE_W     = $clog2(LANES);
    localparam int KEEP_WIDTH = 32;
    localparam int PIX_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } writer_state_t;

    // Two bytes per filled lane; 16 filled lanes yields all ones.
    function automatic logic [KEEP_WIDTH-1:0] keep_for(input logic [LANE_W:0] filled);
        logic [KEEP_WIDTH:0] wide;
        wide = ({{KEEP_WIDTH{1'b0}}, 1'b1} << (2 * filled)) - {{KEEP_WIDTH{1'b0}}, 1'b1};
        return wide[KEEP_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/beat_fifo.sv
// Small synchronous beat FIFO; the entry at the read pointer drives the stream outputs.
module beat_fifo #(
    parameter int WIDTH = 289,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push_en;
    logic             pop_en;

    assign valid   = (count != '0);
    assign full    = (count == FULL_CNT);
    assign head    = mem[rd_ptr];
    assign push_en = push && !full;
    assign pop_en  = pop && valid;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_en) rd_ptr <= rd_ptr + 1'b1;
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/output_stream_writer.sv
// Packs 16-bit conv pixels into 256-bit AXI-Stream beats, one feature map per Start.
// Optional OUTPUT_RELU_EN: negative pixels are stored as zero before packing.
module output_stream_writer
    import conv_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int AXIS_WIDTH = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [7:0]            IMAGE_SIZE,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [AXIS_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  Done_map,
    output logic                  busy
);

    localparam int FIFO_W = AXIS_WIDTH + KEEP_WIDTH + 1;

    writer_state_t          state;
    logic [PIX_CNT_W-1:0]   total;
    logic [PIX_CNT_W-1:0]   pix_cnt;
    logic [LANE_W-1:0]      lane;
    logic [AXIS_WIDTH-1:0]  pack_reg;

    logic [DATA_WIDTH-1:0]  pix;
    logic [AXIS_WIDTH-1:0]  beat_data;
    logic [KEEP_WIDTH-1:0]  beat_keep;
    logic                   accept;
    logic                   last_pix;
    logic                   lane_full;
    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic [FIFO_W-1:0]      fifo_head;

`ifdef OUTPUT_RELU_EN
    assign pix = in_data[DATA_WIDTH-1] ? '0 : in_data;
`else
    assign pix = in_data;
`endif

    assign in_ready  = (state == PACK) && !fifo_full;
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign last_pix  = (pix_cnt == total - 1'b1);
    assign lane_full = (lane == LANE_W'(LANES - 1));
    assign push      = accept && (lane_full || last_pix);
    assign pop       = m_axis_tvalid && m_axis_tready;
    assign beat_keep = keep_for({1'b0, lane} + 1'b1);

    // Lanes above the current one are already zero because the pack register is cleared on every push.
    always_comb begin
        beat_data = pack_reg;
        beat_data[lane*DATA_WIDTH +: DATA_WIDTH] = pix;
    end

    beat_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_beat_fifo (
        .clk       (clk),
        .Reset     (Reset),
        .push      (push),
        .push_data ({last_pix, beat_keep, beat_data}),
        .pop       (pop),
        .head      (fifo_head),
        .valid     (m_axis_tvalid),
        .full      (fifo_full)
    );

    assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = fifo_head;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            total    <= '0;
            pix_cnt  <= '0;
            lane     <= '0;
            pack_reg <= '0;
            Done_map <= 1'b0;
        end else begin
            Done_map <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        total    <= {8'd0, IMAGE_SIZE} * {8'd0, IMAGE_SIZE};
                        pix_cnt  <= '0;
                        lane     <= '0;
                        pack_reg <= '0;
                        state    <= (IMAGE_SIZE == 8'd0) ? DONE : PACK;
                    end
                end
                PACK: begin
                    if (accept) begin
                        pix_cnt <= pix_cnt + 1'b1;
                        if (push) begin
                            pack_reg <= '0;
                            lane     <= '0;
                            if (last_pix) state <= DRAIN;
                        end else begin
                            pack_reg <= beat_data;
                            lane     <= lane + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && m_axis_tlast) state <= DONE;
                end
                DONE: begin
                    Done_map <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_output_stream_writer.sv
// Directed bench for output_stream_writer: packing, tkeep/tlast, backpressure, reset and ReLU.
module tb_output_stream_writer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   image_size = 8'd0;
    logic [15:0]  in_data = 16'd0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [255:0] tdata;
    logic [31:0]  tkeep;
    logic         tvalid;
    logic         tlast;
    logic         tready = 1'b1;
    logic         done_map;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int hs_cyc = 0;

    logic [255:0] q_data [$];
    logic [31:0]  q_keep [$];
    logic         q_last [$];

    output_stream_writer dut (
        .clk           (clk),
        .Reset         (rst_n),
        .Start         (start),
        .IMAGE_SIZE    (image_size),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .m_axis_tdata  (tdata),
        .m_axis_tkeep  (tkeep),
        .m_axis_tvalid (tvalid),
        .m_axis_tlast  (tlast),
        .m_axis_tready (tready),
        .Done_map      (done_map),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n && tvalid && tready) begin
            q_data.push_back(tdata);
            q_keep.push_back(tkeep);
            q_last.push_back(tlast);
            if (tlast) hs_cyc = cyc;
        end
        if (done_map) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [288:0] obs, input logic [288:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_data.delete();
        q_keep.delete();
        q_last.delete();
    endtask

    task automatic do_start(input logic [7:0] n);
        image_size = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] d);
        int w;
        in_data  = d;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 500) begin
            tick();
            w++;
        end
        check("send_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int prev);
        int w;
        w = 0;
        while (done_cnt == prev && w < 2000) begin
            tick();
            w++;
        end
        check("done_seen", done_cnt != prev, 1'b1);
        tick();
    endtask

    function automatic logic [255:0] mk(input int base, input int n);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i*16 +: 16] = 16'(base + i);
        return r;
    endfunction

    initial begin
        int pd;
        int sent;
        logic acc;
        logic ok;
        int nlast;
        logic [255:0] hold;
        logic [255:0] relu_exp;

        // Reset state
        tick();
        tick();
        check("rst_tvalid", tvalid, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done_map, 1'b0);
        check("rst_tdata", tdata, 256'd0);
        rst_n = 1'b1;
        tick();

        // 4x4 map, one full beat
        clear_q();
        pd = done_cnt;
        do_start(8'd4);
        check("t1_busy", busy, 1'b1);
        for (int i = 1; i <= 16; i++) send(16'(i));
        wait_done(pd);
        check("t1_nbeats", q_data.size(), 1);
        check("t1_data", q_data[0], mk(1, 16));
        check("t1_keep", q_keep[0], 32'hFFFF_FFFF);
        check("t1_last", q_last[0], 1'b1);
        check("t1_done_delay", done_cyc - hs_cyc, 2);
        check("t1_done_pulse", done_map, 1'b0);
        check("t1_busy_after", busy, 1'b0);

        // 3x3 map, partial beat
        clear_q();
        pd = done_cnt;
        do_start(8'd3);
        for (int i = 1; i <= 9; i++) send(16'(i));
        wait_done(pd);
        check("t2_nbeats", q_data.size(), 1);
        check("t2_data", q_data[0], mk(1, 9));
        check("t2_keep", q_keep[0], 32'h0003_FFFF);
        check("t2_last", q_last[0], 1'b1);

        // 8x8 map, four beats, Start during the map is ignored
        clear_q();
        pd = done_cnt;
        do_start(8'd8);
        for (int k = 0; k < 64; k++) begin
            send(16'(16'h0100 + k));
            if (k == 20) begin
                check("t3_busy_mid", busy, 1'b1);
                image_size = 8'd2;
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        wait_done(pd);
        check("t3_nbeats", q_data.size(), 4);
        check("t3_lasts", {q_last[0], q_last[1], q_last[2], q_last[3]}, 4'b0001);
        check("t3_data2", q_data[2], mk(16'h0120, 16));
        check("t3_keep3", q_keep[3], 32'hFFFF_FFFF);
        check("t3_busy_after", busy, 1'b0);

        // 16x16 map with downstream stalled
        clear_q();
        pd = done_cnt;
        tready = 1'b0;
        do_start(8'd16);
        sent = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 80; c++) begin
            in_data = 16'(sent + 1);
            acc = in_ready;
            tick();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        check("t4_accepted", sent, 64);
        check("t4_in_ready", in_ready, 1'b0);
        check("t4_tvalid", tvalid, 1'b1);
        hold = tdata;
        tick();
        tick();
        tick();
        check("t4_stable", tdata, hold);
        check("t4_first", hold, mk(1, 16));
        tready = 1'b1;
        for (int k = sent; k < 256; k++) send(16'(k + 1));
        wait_done(pd);
        check("t4_nbeats", q_data.size(), 16);
        ok = 1'b1;
        nlast = 0;
        for (int j = 0; j < q_data.size(); j++) begin
            if (q_data[j] !== mk(16 * j + 1, 16)) ok = 1'b0;
            if (q_keep[j] !== 32'hFFFF_FFFF) ok = 1'b0;
            if (q_last[j]) nlast++;
        end
        check("t4_order", ok, 1'b1);
        check("t4_nlast", nlast, 1);
        check("t4_last15", q_last[15], 1'b1);

        // Reset mid-map, then a clean map
        clear_q();
        do_start(8'd4);
        for (int i = 1; i <= 5; i++) send(16'(i));
        rst_n = 1'b0;
        #1;
        check("t5_tvalid", tvalid, 1'b0);
        check("t5_in_ready", in_ready, 1'b0);
        check("t5_busy", busy, 1'b0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("t5_no_beat", tvalid, 1'b0);
        check("t5_q_empty", q_data.size(), 0);
        clear_q();
        pd = done_cnt;
        do_start(8'd4);
        for (int i = 0; i < 16; i++) send(16'(16'h0020 + i));
        wait_done(pd);
        check("t5_nbeats", q_data.size(), 1);
        check("t5_data", q_data[0], mk(16'h0020, 16));
        check("t5_last", q_last[0], 1'b1);

        // Sign handling: 2x2 map with negative pixels
        clear_q();
        pd = done_cnt;
        do_start(8'd2);
        send(16'h8001);
        send(16'h7FFF);
        send(16'h0003);
        send(16'hFFFF);
        wait_done(pd);
        relu_exp = '0;
`ifdef OUTPUT_RELU_EN
        relu_exp[15:0]  = 16'h0000;
        relu_exp[31:16] = 16'h7FFF;
        relu_exp[47:32] = 16'h0003;
        relu_exp[63:48] = 16'h0000;
`else
        relu_exp[15:0]  = 16'h8001;
        relu_exp[31:16] = 16'h7FFF;
        relu_exp[47:32] = 16'h0003;
        relu_exp[63:48] = 16'hFFFF;
`endif
        check("t6_nbeats", q_data.size(), 1);
        check("t6_data", q_data[0], relu_exp);
        check("t6_keep", q_keep[0], 32'h0000_00FF);

        // Empty map: Done_map without any beat
        clear_q();
        pd = done_cnt;
        do_start(8'd0);
        wait_done(pd);
        check("t7_nbeats", q_data.size(), 0);
        check("t7_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/output_stream_writer.md
Name: output_stream_writer

Overview:
Transmit-side counterpart of the input line buffer. It accepts one 16-bit conv result per handshake from the conv datapath and packs 16 pixels, lane 0 at the LSB, into each 256-bit AXI-Stream beat. Beats are written back to DDR through the DMA. It counts one IMAGE_SIZE x IMAGE_SIZE feature map per Start, asserts tlast on the final beat, and absorbs downstream backpressure in a small beat FIFO.

Parameters:
DATA_WIDTH, 16, pixel width in bits
AXIS_WIDTH, 256, m_axis_tdata width; LANES = AXIS_WIDTH/DATA_WIDTH = 16
FIFO_DEPTH, 4, beat FIFO entries, including the output register; power of 2, at least 2

Ports:
clk  input  1  system clock, all logic on rising edge
Reset  input  1  asynchronous, active-low; clears all state
Start  input  1  single-cycle pulse; begins one feature map
IMAGE_SIZE  input  8  map width = height; sampled on Start
in_data  input  DATA_WIDTH  conv result pixel, two's complement
in_valid  input  1  in_data valid
in_ready  output  1  writer accepts pixel this cycle
m_axis_tdata  output  AXIS_WIDTH  packed beat
m_axis_tkeep  output  AXIS_WIDTH/8  byte enables
m_axis_tvalid  output  1  beat valid
m_axis_tlast  output  1  final beat of map
m_axis_tready  input  1  downstream ready
Done_map  output  1  one-cycle pulse, map fully transmitted
busy  output  1  high from Start acceptance until Done_map

Behaviour:
- Reset asserted (any time, including mid-map): all outputs are 0, FSM goes to IDLE, counters, pack register and FIFO are cleared, and partial data is discarded. No beat is emitted after deassertion until the next Start.
- FSM states:
  - IDLE: on Start, latch total = IMAGE_SIZE*IMAGE_SIZE (16-bit), clear pix_cnt and lane. If total==0, go to DONE; otherwise go to PACK.
  - PACK: in_ready = !fifo_full. A pixel is accepted on in_valid & in_ready and written into lane[lane]; lane and pix_cnt increment. A beat is pushed into the FIFO in the same cycle when the accepted pixel fills lane LANES-1 or is pixel total-1. The pushed beat is formed combinationally from the pack register plus the incoming pixel, then lane returns to 0. The push of the last pixel goes to DRAIN.
  - DRAIN: in_ready = 0. Wait for the handshake of the tlast beat, then go to DONE.
  - DONE: Done_map = 1 for one cycle, then return to IDLE.
- Start is ignored outside IDLE.
- busy = (state != IDLE).
- Partial final beat: unused lanes are zero-filled. m_axis_tkeep = (1 << 2*filled_lanes) - 1; a full beat has all ones.
- tlast is set only on the beat containing pixel total-1.
- Latency: a beat appears on m_axis_tvalid the cycle after its push, provided the FIFO was empty.
- AXI rules:
  - tvalid, once high, holds with tdata/tkeep/tlast stable until tvalid & tready.
  - tvalid never depends combinationally on tready.
- FIFO: simultaneous push and pop when full is not allowed, because in_ready is gated by full. Push and pop in the same cycle when not full or empty leaves the count unchanged.
- in_valid while not in PACK is ignored, and in_ready = 0.

Optional Feature:
OUTPUT_RELU_EN defined: each accepted pixel with MSB = 1 is stored as 0 (ReLU before packing); no added latency.
Undefined: pixels are stored unmodified.

Decomposition:
- Package conv_stream_pkg holds:
  - the LANES and KEEP_WIDTH constants;
  - the writer_state_t enum {IDLE, PACK, DRAIN, DONE};
  - the pixel count width constant (16).
- Sub-module beat_fifo: synchronous FIFO of width AXIS_WIDTH + KEEP_WIDTH + 1, depth FIFO_DEPTH. Its head register drives the m_axis outputs and it provides a full flag.

Test Plan:
- IMAGE_SIZE=4, pixels 0x0001..0x0010, tready=1 -> one beat with lane i = i+1, tkeep = 0xFFFFFFFF, tlast = 1; Done_map pulses 2 cycles after the handshake (DRAIN to DONE).
- IMAGE_SIZE=3, pixels 0x0001..0x0009 -> one beat, lanes 9..15 = 0, tkeep = 0x0003FFFF, tlast = 1.
- IMAGE_SIZE=8, 64 pixels -> 4 beats; tlast only on the 4th beat; busy high throughout, low after Done_map.
- IMAGE_SIZE=16, tready=0 while in_valid=1 -> in_ready drops after exactly 64 accepted pixels. Then release tready -> all 16 beats arrive in order with no loss or duplication, tdata stable while stalled.
- Reset low after 5 pixels of a 4x4 map -> tvalid = in_ready = busy = 0. A new Start with 16 pixels yields exactly one correct beat.
- OUTPUT_RELU_EN defined, pixels 0x8001 and 0x7FFF -> lanes 0x0000 and 0x7FFF. Undefined -> 0x8001 and 0x7FFF.
